// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared defaults and FSM encoding for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

    localparam int NUM_REGS_DEF = 64;
    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshakes, clear request and register-file write port of the arbiter.
interface regfile_wr_arbiter_if
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              clr_req;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wrt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] datain;
    logic              init_done;

    modport master (
        output clr_req,
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready,
        input  wrt, rd, datain, init_done
    );

    modport slave (
        input  clr_req,
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready,
        output wrt, rd, datain, init_done
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: zero-sweeps every entry after reset or clear,
// then round-robins two writeback requesters onto a single registered write port.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);

    // One extra count beyond the last entry marks "sweep finished, enter RUN".
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               wrt_q, wrt_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  datain_q, datain_d;
    logic               init_done_q, init_done_d;

    logic arb_g0, arb_g1;
    logic serve;

    rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_q),
        .grant0     (arb_g0),
        .grant1     (arb_g1)
    );

    assign serve          = (state_q == RUN) && !bus.clr_req;
    assign bus.req0_ready = serve && arb_g0;
    assign bus.req1_ready = serve && arb_g1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        wrt_d    = 1'b0;
        rd_d     = rd_q;
        datain_d = datain_q;
        if (state_q == INIT) begin
            if (cnt_q == CNT_W'(NUM_REGS)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                wrt_d    = 1'b1;
                rd_d     = ADDR_W'(cnt_q);
                datain_d = '0;
                cnt_d    = cnt_q + 1'b1;
            end
        end else if (bus.clr_req) begin
            // Entry 0 goes out immediately so the re-sweep matches the post-reset timing.
            state_d  = INIT;
            wrt_d    = 1'b1;
            rd_d     = '0;
            datain_d = '0;
            cnt_d    = CNT_W'(1);
        end else if (bus.req0_valid && bus.req0_ready) begin
            wrt_d    = 1'b1;
            rd_d     = bus.req0_rd;
            datain_d = bus.req0_data;
            last_d   = 1'b0;
        end else if (bus.req1_valid && bus.req1_ready) begin
            wrt_d    = 1'b1;
            rd_d     = bus.req1_rd;
            datain_d = bus.req1_data;
            last_d   = 1'b1;
        end
        init_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            wrt_q       <= 1'b0;
            rd_q        <= '0;
            datain_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wrt_q       <= wrt_d;
            rd_q        <= rd_d;
            datain_q    <= datain_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.wrt       = wrt_q;
    assign bus.rd        = rd_q;
    assign bus.datain    = datain_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: sweep, single/contended writes, clear and reset.
module tb_regfile_wr_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    regfile_wr_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    regfile_wr_arbiter #(.NUM_REGS(64), .ADDR_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.clr_req    = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
    endtask

    // Expects to be entered right after the clr_req/reset edge: checks entries first..63 then RUN.
    task automatic check_sweep(input int first, input string name);
        for (int i = first; i < 64; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wrt !== 1'b1 || bus.rd !== 6'(i) || bus.datain !== 32'd0 ||
                bus.init_done !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s entry %0d: wrt=%b rd=%0d datain=%h init_done=%b rdy=%b%b, required wrt=1 rd=%0d datain=0 init_done=0 rdy=00",
                         name, i, bus.wrt, bus.rd, bus.datain, bus.init_done, bus.req0_ready, bus.req1_ready, i);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.init_done !== 1'b1 || bus.wrt !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done: init_done=%b wrt=%b, required init_done=1 wrt=0", name, bus.init_done, bus.wrt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.wrt, bus.rd, bus.datain, bus.init_done, bus.req0_ready, bus.req1_ready} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_state: wrt=%b rd=%0d datain=%h init_done=%b rdy=%b%b, required all zero",
                     bus.wrt, bus.rd, bus.datain, bus.init_done, bus.req0_ready, bus.req1_ready);
        end
        rst_n = 1'b1;
        // Valids stay high across the sweep: readies must still be held low.
        check_sweep(0, "sweep");
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 6'd5;
        bus.req0_data  = 32'hA5A5_A5A5;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single0_ready: rdy=%b%b, required 10", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b1 || bus.rd !== 6'd5 || bus.datain !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL single0_write: wrt=%b rd=%0d datain=%h, required 1/5/a5a5a5a5", bus.wrt, bus.rd, bus.datain);
        end
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b0 || bus.rd !== 6'd5 || bus.datain !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL idle_hold: wrt=%b rd=%0d datain=%h, required 0/5/a5a5a5a5", bus.wrt, bus.rd, bus.datain);
        end
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 6'd9;
        bus.req1_data  = 32'h0000_0099;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single1_ready: rdy=%b%b, required 01", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b1 || bus.rd !== 6'd9 || bus.datain !== 32'h99) begin
            n_err++;
            $display("FAIL single1_write: wrt=%b rd=%0d datain=%h, required 1/9/99", bus.wrt, bus.rd, bus.datain);
        end
        bus.req1_valid = 1'b0;
    endtask

    // Last grant went to requester 1, so requester 0 wins first.
    task automatic test_back_to_back();
        logic        exp0;
        logic [5:0]  exp_rd;
        logic [31:0] exp_data;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 6'd1;
        bus.req0_data  = 32'h1111_0001;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 6'd2;
        bus.req1_data  = 32'h2222_0002;
        for (int k = 0; k < 4; k++) begin
            exp0     = (k % 2 == 0);
            exp_rd   = exp0 ? 6'd1 : 6'd2;
            exp_data = exp0 ? 32'h1111_0001 : 32'h2222_0002;
            #1;
            n_cmp++;
            if (bus.req0_ready !== exp0 || bus.req1_ready !== !exp0) begin
                n_err++;
                $display("FAIL rr_grant %0d: rdy=%b%b, required %b%b", k, bus.req0_ready, bus.req1_ready, exp0, !exp0);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.wrt !== 1'b1 || bus.rd !== exp_rd || bus.datain !== exp_data) begin
                n_err++;
                $display("FAIL rr_write %0d: wrt=%b rd=%0d datain=%h, required 1/%0d/%h",
                         k, bus.wrt, bus.rd, bus.datain, exp_rd, exp_data);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_same_rd();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 6'd7;
        bus.req0_data  = 32'h11;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 6'd7;
        bus.req1_data  = 32'h22;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL same_rd_grant0: rdy=%b%b, required 10", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b1 || bus.rd !== 6'd7 || bus.datain !== 32'h11) begin
            n_err++;
            $display("FAIL same_rd_first: wrt=%b rd=%0d datain=%h, required 1/7/11", bus.wrt, bus.rd, bus.datain);
        end
        bus.req0_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL same_rd_grant1: rdy=%b%b, required 01", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b1 || bus.rd !== 6'd7 || bus.datain !== 32'h22) begin
            n_err++;
            $display("FAIL same_rd_second: wrt=%b rd=%0d datain=%h, required 1/7/22", bus.wrt, bus.rd, bus.datain);
        end
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_clr();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 6'd3;
        bus.req1_data  = 32'h33;
        bus.clr_req    = 1'b1;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready: rdy=%b%b, required 00", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.init_done !== 1'b0 || bus.wrt !== 1'b1 || bus.rd !== 6'd0 || bus.datain !== 32'd0) begin
            n_err++;
            $display("FAIL clr_restart: init_done=%b wrt=%b rd=%0d datain=%h, required 0/1/0/0",
                     bus.init_done, bus.wrt, bus.rd, bus.datain);
        end
        bus.clr_req    = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wrt !== 1'b1 || bus.rd !== 6'(i) || bus.init_done !== 1'b0) begin
                n_err++;
                $display("FAIL clr_sweep entry %0d: wrt=%b rd=%0d init_done=%b, required 1/%0d/0",
                         i, bus.wrt, bus.rd, bus.init_done, i);
            end
            // A clear request inside the sweep must not restart it.
            bus.clr_req = (i == 10);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.init_done !== 1'b1 || bus.wrt !== 1'b0) begin
            n_err++;
            $display("FAIL clr_done: init_done=%b wrt=%b, required 1/0", bus.init_done, bus.wrt);
        end
    endtask

    task automatic test_midsweep_reset();
        // Leave the pointer at requester 0 so the post-reset contention shows the pointer reset.
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 6'd12;
        bus.req0_data  = 32'hC0DE;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.clr_req    = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (bus.wrt !== 1'b1 || bus.rd !== 6'd30) begin
            n_err++;
            $display("FAIL pre_reset_entry: wrt=%b rd=%0d, required 1/30", bus.wrt, bus.rd);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.wrt, bus.rd, bus.datain, bus.init_done, bus.req0_ready, bus.req1_ready} !== 42'd0) begin
            n_err++;
            $display("FAIL async_reset: wrt=%b rd=%0d datain=%h init_done=%b rdy=%b%b, required all zero",
                     bus.wrt, bus.rd, bus.datain, bus.init_done, bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep(0, "resweep");
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ptr_reset: rdy=%b%b, required 10", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_same_rd();
        test_clr();
        test_midsweep_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 64, meaning number of register-file entries swept at init.
REQ-002 Parameter ADDR_W, default 6, meaning register address width.
REQ-003 Parameter DATA_W, default 32, meaning write data width.
REQ-004 clk  input  1  the single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 clr_req  input  1  pulse requesting a full re-clear of the register file.
REQ-007 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-008 req0_rd  input  ADDR_W  requester 0 destination register.
REQ-009 req0_data  input  DATA_W  requester 0 write data.
REQ-010 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-011 req1_valid, req1_rd, req1_data, req1_ready  same directions, widths and meanings for requester 1 (load writeback).
REQ-012 wrt  output  1  write enable to register-file write port.
REQ-013 rd  output  ADDR_W  register-file write address.
REQ-014 datain  output  DATA_W  register-file write data.
REQ-015 init_done  output  1  high when sweep complete and requesters are being served.

Function
REQ-016 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-017 INIT: per cycle, drive wrt=1, rd=sweep counter, datain=0; counter counts 0..NUM_REGS-1, one entry per cycle.
REQ-018 INIT -> RUN on the cycle after the write of entry NUM_REGS-1 is driven; sweep takes exactly NUM_REGS cycles.
REQ-019 RUN -> INIT on a posedge with clr_req=1; sweep counter restarts at 0.
REQ-020 clr_req in INIT SHALL be ignored (sweep not restarted).
REQ-021 req0_ready and req1_ready SHALL be 0 throughout INIT, and 0 in RUN on the cycle clr_req=1.
REQ-022 In RUN, readies are combinational from valids and the last-grant pointer; a transfer occurs when valid and ready are both high at a posedge.
REQ-023 At most one ready high per cycle.
REQ-024 Only one valid high: that requester gets ready.
REQ-025 Both valid: grant the requester not granted last (round-robin); pointer updates only on a transfer.
REQ-026 Last-grant pointer reset value = 1, so requester 0 wins the first contention.
REQ-027 wrt, rd, datain SHALL be registered; a transfer at posedge N drives wrt=1 with that rd/datain during cycle N+1 (latency 1), so outputs are stable at the register file's negedge write.
REQ-028 In RUN with no transfer, wrt=0; rd and datain hold previous values.
REQ-029 init_done SHALL be registered and equal 1 exactly while state is RUN.
REQ-030 A loser keeps valid/rd/data stable until granted; the arbiter SHALL NOT drop or reorder a held request.
REQ-031 Both requesters targeting the same rd: writes issue in grant order; the later grant is the final value.

Reset
REQ-032 rst_n low SHALL immediately force state=INIT, sweep counter=0, pointer=1, wrt=0, rd=0, datain=0, init_done=0, both readies 0.
REQ-033 Reset asserted mid-sweep or mid-RUN discards any in-flight transfer; sweep restarts from entry 0 after release.
REQ-034 First sweep write (rd=0) is driven in the first cycle after rst_n deasserts.

Structure
REQ-035 Shared package SHALL hold NUM_REGS, ADDR_W, DATA_W defaults and the FSM state encoding (INIT=0, RUN=1).
REQ-036 The round-robin two-way grant logic SHALL be a sub-module rr_arb2 (inputs: two valids, pointer; outputs: two grants).
REQ-037 Top-level SHALL contain FSM, sweep counter and output registers only.

Verification
REQ-038 Release reset -> wrt=1 for 64 consecutive cycles with rd=0..63, datain=0; init_done=1 on cycle 65; readies 0 throughout.
REQ-039 RUN, req0_valid only with rd=5, data=0xA5A5A5A5 -> req0_ready=1 same cycle; next cycle wrt=1, rd=5, datain=0xA5A5A5A5.
REQ-040 RUN, both valid held 4 cycles (req0 rd=1, req1 rd=2) -> grants 0,1,0,1; wrt every cycle, rd sequence 1,2,1,2.
REQ-041 RUN, clr_req pulse while req1_valid=1 -> req1_ready=0; next cycle init_done=0 and sweep restarts at rd=0.
REQ-042 rst_n pulsed low at sweep entry 30 -> outputs zero immediately; after release sweep restarts at rd=0, completes 64 writes.
REQ-043 Both valid, same rd=7, data 0x11 (req0) / 0x22 (req1) -> writes 0x11 then 0x22 to rd 7 on consecutive cycles.
